noc_router_rr: RTL and testbench
================================

# noc_router_rr

Parametrised three-port (East, West, Local) NoC router: the next generation of the team's router tile. Each input port has its own DEPTH-entry FIFO. Each head flit is routed by comparing its destination field with LOCAL_IP. Each output port has a fair round-robin arbiter and a registered output stage. Backpressure comes from the downstream FIFOs' full and almost_full flags. Instances chain East/West into a 1-D line of tiles, with Local attached to the tile's IP.

## Interface
- WIDTH, 16, flit width in bits.
- DEPTH, 32, entries per input FIFO; power of two, ≥4.
- ADDR_W, 2, width of the destination field, taken from flit bits [WIDTH-1 -: ADDR_W].
- LOCAL_IP, 0, this tile's address (ADDR_W bits).
- STAT_W, 16, width of each statistics counter; used only with the stats macro.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- writeE / writeW / writeL  in  1  push the matching dataIn into that input FIFO.
- dataInE / dataInW / dataInL  in  WIDTH  input flits.
- readFullE / readFullW / readFullL  in  1  downstream FIFO full, per output.
- read_almostfullE / read_almostfullW / read_almostfullL  in  1  downstream FIFO almost_full, per output.
- dataOutE / dataOutW / dataOutL  out  WIDTH  registered output flits.
- writeOutE / writeOutW / writeOutL  out  1  registered write strobes to downstream.
- fullE / fullW / fullL  out  1  input FIFO full (count == DEPTH).
- almost_fullE / almost_fullW / almost_fullL  out  1  input FIFO count ≥ DEPTH-1.
- stat_flits  out  3*STAT_W  forwarded-flit counters packed {L,W,E}; present only with NOC_ROUTER_STATS_EN.

## Operation
- **Input FIFOs**
  - Show-ahead: the head flit and its empty flag are visible combinationally.
  - Count is ADDR_BITS+1 wide ($clog2(DEPTH)+1); pointers wrap modulo DEPTH.
  - A write while full is dropped; FIFO contents and count are unchanged.
  - Write and read in the same cycle: both take effect and the count holds. On an empty FIFO the write is stored, never bypassed.
- **Routing** of each non-empty head, with dest = head[WIDTH-1 -: ADDR_W], unsigned compare:
  - dest == LOCAL_IP → Local.
  - dest > LOCAL_IP → East.
  - dest < LOCAL_IP → West.
  - There is no U-turn check.
- **Arbitration**, one arbiter per output.
  - A request is raised by an input that is non-empty and whose head routes to that output.
  - The output is eligible only when its readFull and read_almostfull are both low.
  - The grant goes to the first requester after the last granted input, in the cyclic order E→W→L→E.
  - The pointer advances only on a grant; after reset the pointer is L, so E has first priority.
  - An input's head targets exactly one output, so each input gets at most one grant per cycle.
- **Grant effects**
  - The granted input FIFO pops at the next edge.
  - At the same edge the output register loads the head flit and writeOut goes to 1.
  - With no grant, writeOut goes to 0 and dataOut holds its previous value.
- Up to three flits are forwarded per cycle, one per output, when the routes are disjoint.

## Timing
- Reset values: dataOut* = 0, writeOut* = 0, full* = 0, almost_full* = 0; FIFOs empty; arbiter pointers = L; counters = 0.
- Latency:
  - write* high in cycle t makes the flit a FIFO head in cycle t+1.
  - It is granted in cycle t+1 if eligible.
  - writeOut is high in cycle t+2.
  - Minimum latency is therefore 2 cycles.
- Throughput: 1 flit/cycle per output while downstream almost_full stays low.
- Backpressure: because grants are gated by downstream almost_full, with at most one flit in flight the downstream FIFO never overflows. The full input is an additional hard gate.
- full*/almost_full* are derived from the registered count. They reflect a write one cycle after the edge that performs it.
- Reset asserted mid-transfer: outputs clear immediately (asynchronously) and in-flight flits are lost. No grant is issued while reset is high.

## Configuration
- NOC_ROUTER_STATS_EN defined:
  - Adds the stat_flits port.
  - Three STAT_W-bit counters, each incrementing on every writeOut load for its output.
  - Counters saturate at all-ones and clear on reset.
- NOC_ROUTER_STATS_EN undefined:
  - The port and counters are absent.
  - Forwarding behaviour is otherwise identical.

## Test plan
- LOCAL_IP=1: write dataInW=16'h8123 (dest 2) at cycle 0 → writeOutE=1 with dataOutE=16'h8123 in cycle 2; writeOutW=writeOutL=0.
- E, W and L each hold a flit with dest=1 (LOCAL_IP=1), with readFullL and read_almostfullL held low → Local outputs the E, W, L flits in that order on consecutive cycles, and the pointer ends at L.
- Stream 10 flits E→Local; raise read_almostfullL at cycle 5 and lower it at cycle 9 → no writeOutL during the stalled cycles; all 10 flits arrive in order with none lost or duplicated.
- Write 34 flits into fifoL with no grants possible → fullL=1 after the 32nd write and almost_fullL=1 after the 31st; writes 33 and 34 are dropped; draining yields exactly flits 1..32.
- Simultaneous disjoint routes (E→W, W→E, L→L) → all three writeOut strobes high in the same cycle. Reset asserted mid-stream → all outputs 0 at once; after release, FIFOs are empty and E has first priority.
- With NOC_ROUTER_STATS_EN and STAT_W=4, forward 20 flits to East → stat_flits[3:0] = 4'hF (saturated); the W and L counters = 0.

Source files
------------

// File: rtl/noc_router_rr.sv
// ---------------------------------------------------------------------------
// noc_router_rr
//
// Three-port (East, West, Local) NoC router tile. Each input port owns a
// DEPTH-entry show-ahead FIFO. Every non-empty head flit is routed by an
// unsigned compare of its destination field against LOCAL_IP. Each output has
// a round-robin arbiter (cyclic order E -> W -> L) followed by a registered
// output stage. A grant is only issued while the downstream full and
// almost_full flags are both low.
//
// Ports
//   clk                           sole clock, rising edge
//   reset                         asynchronous, active-high, clears all state
//   writeE/W/L, dataInE/W/L       input flit pushes into the per-port FIFOs
//   readFullE/W/L                 downstream FIFO full, per output
//   read_almostfullE/W/L          downstream FIFO almost_full, per output
//   dataOutE/W/L, writeOutE/W/L   registered output flits and write strobes
//   fullE/W/L, almost_fullE/W/L   input FIFO status (count==DEPTH, >=DEPTH-1)
//   stat_flits                    forwarded-flit counters {L,W,E}
//
// Optional feature macro: NOC_ROUTER_STATS_EN
//   When defined, adds stat_flits and three saturating STAT_W-bit counters,
//   one per output, that increment on every writeOut load.
// ---------------------------------------------------------------------------
module noc_router_rr #(
    parameter int          WIDTH    = 16,
    parameter int          DEPTH    = 32,
    parameter int          ADDR_W   = 2,
    parameter int unsigned LOCAL_IP = 0,
    parameter int          STAT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              writeE,
    input  logic              writeW,
    input  logic              writeL,
    input  logic [WIDTH-1:0]  dataInE,
    input  logic [WIDTH-1:0]  dataInW,
    input  logic [WIDTH-1:0]  dataInL,
    input  logic              readFullE,
    input  logic              readFullW,
    input  logic              readFullL,
    input  logic              read_almostfullE,
    input  logic              read_almostfullW,
    input  logic              read_almostfullL,
    output logic [WIDTH-1:0]  dataOutE,
    output logic [WIDTH-1:0]  dataOutW,
    output logic [WIDTH-1:0]  dataOutL,
    output logic              writeOutE,
    output logic              writeOutW,
    output logic              writeOutL,
    output logic              fullE,
    output logic              fullW,
    output logic              fullL,
    output logic              almost_fullE,
`ifdef NOC_ROUTER_STATS_EN
    output logic [3*STAT_W-1:0] stat_flits,
`endif
    output logic              almost_fullW,
    output logic              almost_fullL
);

    localparam int ADDR_BITS = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LIP = ADDR_W'(LOCAL_IP);

    // Port index used throughout: 0 = East, 1 = West, 2 = Local.
    localparam logic [1:0] P_E = 2'd0;
    localparam logic [1:0] P_W = 2'd1;
    localparam logic [1:0] P_L = 2'd2;

    // Round-robin pick: first requester strictly after ptr in order 0->1->2->0.
    // Returns {valid, index}. Iterating from the farthest candidate down lets
    // the nearest requester overwrite the result without an early exit.
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        int         c;
        res = 3'b000;
        for (int k = 3; k >= 1; k--) begin
            c = (int'(ptr) + k) % 3;
            if (req[c]) res = {1'b1, 2'(c)};
        end
        return res;
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

    // ---------------------------------------------------------------- inputs
    logic [WIDTH-1:0]     w_din   [3];
    logic [2:0]           w_wr;
    logic [2:0]           w_dn_full;
    logic [2:0]           w_dn_afull;

    assign w_din[0]   = dataInE;
    assign w_din[1]   = dataInW;
    assign w_din[2]   = dataInL;
    assign w_wr       = {writeL, writeW, writeE};
    assign w_dn_full  = {readFullL, readFullW, readFullE};
    assign w_dn_afull = {read_almostfullL, read_almostfullW, read_almostfullE};

    // ---------------------------------------------------------------- FIFOs
    logic [WIDTH-1:0]     r_mem   [3][DEPTH];
    logic [ADDR_BITS-1:0] r_wptr  [3];
    logic [ADDR_BITS-1:0] r_rptr  [3];
    logic [ADDR_BITS:0]   r_cnt   [3];

    logic [2:0]           w_empty;
    logic [2:0]           w_full;
    logic [2:0]           w_afull;
    logic [2:0]           w_push;
    logic [2:0]           w_pop;
    logic [WIDTH-1:0]     w_head  [3];

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            w_empty[p] = (r_cnt[p] == '0);
            w_full[p]  = (r_cnt[p] == (ADDR_BITS+1)'(DEPTH));
            w_afull[p] = (r_cnt[p] >= (ADDR_BITS+1)'(DEPTH-1));
            // Writes while full are dropped; a write into an empty FIFO is
            // stored and only becomes the head on the following cycle.
            w_push[p]  = w_wr[p] & ~w_full[p];
            w_head[p]  = r_mem[p][r_rptr[p]];
        end
    end

    // Storage carries no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 3; p++) begin
            if (w_push[p]) r_mem[p][r_wptr[p]] <= w_din[p];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 3; p++) begin
                r_wptr[p] <= '0;
                r_rptr[p] <= '0;
                r_cnt[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < 3; p++) begin
                if (w_push[p]) r_wptr[p] <= r_wptr[p] + ADDR_BITS'(1);
                if (w_pop[p])  r_rptr[p] <= r_rptr[p] + ADDR_BITS'(1);
                case ({w_push[p], w_pop[p]})
                    2'b10:   r_cnt[p] <= r_cnt[p] + (ADDR_BITS+1)'(1);
                    2'b01:   r_cnt[p] <= r_cnt[p] - (ADDR_BITS+1)'(1);
                    default: r_cnt[p] <= r_cnt[p];
                endcase
            end
        end
    end

    // ---------------------------------------------------------------- routing
    logic [1:0]           w_route [3];
    logic [ADDR_W-1:0]    w_dest  [3];

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            w_dest[p] = w_head[p][WIDTH-1 -: ADDR_W];
            if (w_dest[p] == LIP)     w_route[p] = P_L;
            else if (w_dest[p] > LIP) w_route[p] = P_E;
            else                      w_route[p] = P_W;
        end
    end

    // ---------------------------------------------------------------- arbitration
    logic [1:0]           r_ptr     [3];
    logic [2:0]           w_req     [3];
    logic [2:0]           w_pick    [3];
    logic [2:0]           w_gnt_vld;
    logic [1:0]           w_gnt_idx [3];

    always_comb begin
        w_pop = 3'b000;
        for (int o = 0; o < 3; o++) begin
            for (int p = 0; p < 3; p++) begin
                w_req[o][p] = ~w_empty[p] & (w_route[p] == 2'(o));
            end
            w_pick[o]    = rr_pick(w_req[o], r_ptr[o]);
            // Downstream almost_full gates the grant so the single flit in
            // flight always has room; full is a redundant hard stop.
            w_gnt_vld[o] = w_pick[o][2] & ~w_dn_full[o] & ~w_dn_afull[o] & ~reset;
            w_gnt_idx[o] = w_pick[o][1:0];
        end
        // Each head routes to one output only, so no input is popped twice.
        for (int o = 0; o < 3; o++) begin
            for (int p = 0; p < 3; p++) begin
                if (w_gnt_vld[o] && (w_gnt_idx[o] == 2'(p))) w_pop[p] = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- output stage
    logic [WIDTH-1:0]     r_dout [3];
    logic [2:0]           r_wout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int o = 0; o < 3; o++) begin
                r_dout[o] <= '0;
                r_ptr[o]  <= P_L;
            end
            r_wout <= 3'b000;
        end else begin
            for (int o = 0; o < 3; o++) begin
                r_wout[o] <= w_gnt_vld[o];
                if (w_gnt_vld[o]) begin
                    r_dout[o] <= w_head[w_gnt_idx[o]];
                    r_ptr[o]  <= w_gnt_idx[o];
                end
            end
        end
    end

    assign dataOutE     = r_dout[0];
    assign dataOutW     = r_dout[1];
    assign dataOutL     = r_dout[2];
    assign writeOutE    = r_wout[0];
    assign writeOutW    = r_wout[1];
    assign writeOutL    = r_wout[2];
    assign fullE        = w_full[0];
    assign fullW        = w_full[1];
    assign fullL        = w_full[2];
    assign almost_fullE = w_afull[0];
    assign almost_fullW = w_afull[1];
    assign almost_fullL = w_afull[2];

`ifdef NOC_ROUTER_STATS_EN
    // ---------------------------------------------------------------- statistics
    logic [STAT_W-1:0]    r_stat [3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int o = 0; o < 3; o++) r_stat[o] <= '0;
        end else begin
            for (int o = 0; o < 3; o++) begin
                if (w_gnt_vld[o]) r_stat[o] <= sat_inc(r_stat[o]);
            end
        end
    end

    assign stat_flits = {r_stat[2], r_stat[1], r_stat[0]};
`endif

endmodule

// File: tb/tb_noc_router_rr.sv
// ---------------------------------------------------------------------------
// tb_noc_router_rr
//
// Scoreboard bench for noc_router_rr with LOCAL_IP=1, DEPTH=32. Expected
// flits are queued per output when driven and compared in order whenever
// the matching writeOut strobe is seen. Cycle-exact checks cover latency,
// back-to-back arbitration, stalls, FIFO full/almost_full and reset.
// ---------------------------------------------------------------------------
module tb_noc_router_rr;

    localparam int WIDTH    = 16;
    localparam int DEPTH    = 32;
    localparam int ADDR_W   = 2;
    localparam int LOCAL_IP = 1;
`ifdef NOC_ROUTER_STATS_EN
    localparam int STAT_W   = 4;
    logic [3*STAT_W-1:0] stat_flits;
`else
    localparam int STAT_W   = 16;
`endif

    logic clk;
    logic reset;
    logic writeE, writeW, writeL;
    logic [WIDTH-1:0] dataInE, dataInW, dataInL;
    logic readFullE, readFullW, readFullL;
    logic read_almostfullE, read_almostfullW, read_almostfullL;
    logic [WIDTH-1:0] dataOutE, dataOutW, dataOutL;
    logic writeOutE, writeOutW, writeOutL;
    logic fullE, fullW, fullL;
    logic almost_fullE, almost_fullW, almost_fullL;

    noc_router_rr #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .LOCAL_IP(LOCAL_IP), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .writeE(writeE), .writeW(writeW), .writeL(writeL),
        .dataInE(dataInE), .dataInW(dataInW), .dataInL(dataInL),
        .readFullE(readFullE), .readFullW(readFullW), .readFullL(readFullL),
        .read_almostfullE(read_almostfullE), .read_almostfullW(read_almostfullW),
        .read_almostfullL(read_almostfullL),
        .dataOutE(dataOutE), .dataOutW(dataOutW), .dataOutL(dataOutL),
        .writeOutE(writeOutE), .writeOutW(writeOutW), .writeOutL(writeOutL),
        .fullE(fullE), .fullW(fullW), .fullL(fullL),
        .almost_fullE(almost_fullE),
`ifdef NOC_ROUTER_STATS_EN
        .stat_flits(stat_flits),
`endif
        .almost_fullW(almost_fullW), .almost_fullL(almost_fullL)
    );

    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] qE[$];
    logic [WIDTH-1:0] qW[$];
    logic [WIDTH-1:0] qL[$];
    logic [WIDTH-1:0] mon_exp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        writeE = 1'b0; writeW = 1'b0; writeL = 1'b0;
        dataInE = '0; dataInW = '0; dataInL = '0;
        readFullE = 1'b0; readFullW = 1'b0; readFullL = 1'b0;
        read_almostfullE = 1'b0; read_almostfullW = 1'b0; read_almostfullL = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((qE.size() + qW.size() + qL.size()) != 0 && n < 200) begin
            tick();
            n++;
        end
        check_val(tag, 32'(qE.size() + qW.size() + qL.size()), 32'd0);
        repeat (3) tick();
    endtask

    // Scoreboard monitor: every strobe must match the oldest queued flit.
    always @(negedge clk) begin
        if (!reset) begin
            if (writeOutE) begin
                check_val("spurious_E", 32'(qE.size() > 0), 32'd1);
                if (qE.size() > 0) begin
                    mon_exp = qE.pop_front();
                    check_val("dataOutE", 32'(dataOutE), 32'(mon_exp));
                end
            end
            if (writeOutW) begin
                check_val("spurious_W", 32'(qW.size() > 0), 32'd1);
                if (qW.size() > 0) begin
                    mon_exp = qW.pop_front();
                    check_val("dataOutW", 32'(dataOutW), 32'(mon_exp));
                end
            end
            if (writeOutL) begin
                check_val("spurious_L", 32'(qL.size() > 0), 32'd1);
                if (qL.size() > 0) begin
                    mon_exp = qL.pop_front();
                    check_val("dataOutL", 32'(dataOutL), 32'(mon_exp));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        repeat (2) tick();

        // Reset state
        check_val("rst_wout", 32'({writeOutE, writeOutW, writeOutL}), 32'd0);
        check_val("rst_doutEW", {dataOutE, dataOutW}, 32'd0);
        check_val("rst_doutL", 32'(dataOutL), 32'd0);
        check_val("rst_flags", 32'({fullE, fullW, fullL, almost_fullE, almost_fullW, almost_fullL}), 32'd0);
        reset = 1'b0;
        tick();

        // West input, dest 2 -> East output, 2-cycle latency
        writeW = 1'b1; dataInW = 16'h8123; qE.push_back(16'h8123);
        tick();
        writeW = 1'b0;
        check_val("t1_c1_woutE", 32'(writeOutE), 32'd0);
        tick();
        check_val("t1_woutE", 32'(writeOutE), 32'd1);
        check_val("t1_doutE", 32'(dataOutE), 32'h8123);
        check_val("t1_woutWL", 32'({writeOutW, writeOutL}), 32'd0);
        drain("t1_drain");

        // E, W, L all waiting for Local -> E, W, L on consecutive cycles
        read_almostfullL = 1'b1;
        writeE = 1'b1; dataInE = 16'h4001;
        writeW = 1'b1; dataInW = 16'h4002;
        writeL = 1'b1; dataInL = 16'h4003;
        qL.push_back(16'h4001); qL.push_back(16'h4002); qL.push_back(16'h4003);
        tick();
        writeE = 1'b0; writeW = 1'b0; writeL = 1'b0;
        tick();
        check_val("t2_stalled", 32'(writeOutL), 32'd0);
        read_almostfullL = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val($sformatf("t2_woutL%0d", k), 32'(writeOutL), 32'd1);
        end
        drain("t2_drain");

        // Pointer left at L: E must win over W next
        read_almostfullL = 1'b1;
        writeE = 1'b1; dataInE = 16'h4011;
        writeW = 1'b1; dataInW = 16'h4012;
        qL.push_back(16'h4011); qL.push_back(16'h4012);
        tick();
        writeE = 1'b0; writeW = 1'b0;
        read_almostfullL = 1'b0;
        drain("t2_ptr_drain");

        // Stream of 10 flits E -> Local with an almost_full stall
        for (int i = 0; i < 10; i++) begin
            read_almostfullL = (i >= 5 && i < 9);
            writeE = 1'b1;
            dataInE = 16'(16'h4100 + i);
            qL.push_back(16'(16'h4100 + i));
            if (i >= 6)      check_val($sformatf("t3_stall%0d", i), 32'(writeOutL), 32'd0);
            else if (i >= 2) check_val($sformatf("t3_flow%0d", i), 32'(writeOutL), 32'd1);
            tick();
        end
        writeE = 1'b0;
        read_almostfullL = 1'b0;
        drain("t3_drain");

        // Fill Local FIFO with grants blocked by readFullL
        readFullL = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            writeL = 1'b1;
            dataInL = 16'(16'h4200 + k);
            if (k <= 32) qL.push_back(16'(16'h4200 + k));
            tick();
            if (k == 30) check_val("t4_af30", 32'(almost_fullL), 32'd0);
            if (k == 31) check_val("t4_af31", 32'({almost_fullL, fullL}), 32'b10);
            if (k >= 32) check_val($sformatf("t4_full%0d", k), 32'(fullL), 32'd1);
        end
        writeL = 1'b0;
        check_val("t4_no_out", 32'(writeOutL), 32'd0);
        readFullL = 1'b0;
        drain("t4_drain");
        check_val("t4_flags_after", 32'({fullL, almost_fullL}), 32'd0);

        // Disjoint routes: E->W, W->E, L->L in the same cycle
        writeE = 1'b1; dataInE = 16'h0501; qW.push_back(16'h0501);
        writeW = 1'b1; dataInW = 16'h8502; qE.push_back(16'h8502);
        writeL = 1'b1; dataInL = 16'h4503; qL.push_back(16'h4503);
        tick();
        writeE = 1'b0; writeW = 1'b0; writeL = 1'b0;
        tick();
        check_val("t5_all3", 32'({writeOutE, writeOutW, writeOutL}), 32'b111);
        drain("t5_drain");

        // Reset in the middle of two streams (E->L, W->E)
        for (int i = 0; i < 6; i++) begin
            writeE = 1'b1; dataInE = 16'(16'h4600 + i); qL.push_back(16'(16'h4600 + i));
            writeW = 1'b1; dataInW = 16'(16'h8700 + i); qE.push_back(16'(16'h8700 + i));
            tick();
        end
        writeE = 1'b0; writeW = 1'b0;
        check_val("t6_pre_wout", 32'({writeOutE, writeOutL}), 32'b11);
        reset = 1'b1;
        qE.delete(); qW.delete(); qL.delete();
        #1;
        check_val("t6_rst_wout", 32'({writeOutE, writeOutW, writeOutL}), 32'd0);
        check_val("t6_rst_doutEL", {dataOutE, dataOutL}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        check_val("t6_flags", 32'({fullE, fullW, fullL, almost_fullE, almost_fullW, almost_fullL}), 32'd0);
        repeat (3) tick();
        check_val("t6_empty", 32'({writeOutE, writeOutW, writeOutL}), 32'd0);

        // After reset the Local pointer is back at L: E wins first
        writeE = 1'b1; dataInE = 16'h4801;
        writeW = 1'b1; dataInW = 16'h4802;
        writeL = 1'b1; dataInL = 16'h4803;
        qL.push_back(16'h4801); qL.push_back(16'h4802); qL.push_back(16'h4803);
        tick();
        writeE = 1'b0; writeW = 1'b0; writeL = 1'b0;
        drain("t6_prio_drain");

`ifdef NOC_ROUTER_STATS_EN
        // Saturating statistics counter on the East output
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            writeW = 1'b1; dataInW = 16'(16'h8900 + i); qE.push_back(16'(16'h8900 + i));
            tick();
        end
        writeW = 1'b0;
        drain("stat_drain");
        check_val("stat_E", 32'(stat_flits[3:0]), 32'hF);
        check_val("stat_WL", 32'(stat_flits[11:4]), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
